// File: rtl/shreg_pkg.sv
// Shared encodings for the flop-chain sequencer: command codes, FSM states
// and a small elaboration-time helper.
package shreg_pkg;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_NOP    = 2'b00;
  localparam cmd_t CMD_LOAD   = 2'b01;
  localparam cmd_t CMD_CLEAR  = 2'b10;
  localparam cmd_t CMD_PRESET = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StShift = 3'd1;
  localparam state_t StClrp  = 3'd2;
  localparam state_t StPsetp = 3'd3;
  localparam state_t StDone  = 3'd4;

  // Larger of two unsigned values; used to size the shared counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter shared by the shift phase and the clear/preset pulse
// timing. Saturates at zero instead of wrapping.
module seq_down_cnt #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: load has priority over decrement; no decrement past zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - Width'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the edge on which the count reaches zero, so the caller can leave
  // its timed state on that same edge.
  assign zero_o = (cnt_d == '0);

endmodule

// File: rtl/shreg_seq.sv
// Command sequencer for a serial D-flop chain. Turns LOAD / CLEAR / PRESET
// commands into timed shift-enable, serial-data, clear and preset pulses.
// Every output is a flop decoded from the next state.
module shreg_seq
  import shreg_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic         Ck,
  input  logic         CLR,
  input  logic         start,
  input  logic [1:0]   cmd,
  input  logic [N-1:0] din,
  output logic         busy,
  output logic         done,
  output logic         ff_d,
  output logic         ff_en,
  output logic         ff_clr_n,
  output logic         ff_pset_n
);

  localparam int unsigned CntW = $clog2(max_u(N, CLR_CYCLES) + 1);

  state_t         state_q, state_d;
  logic [N-1:0]   sreg_q, sreg_d;

  logic           cnt_load;
  logic [CntW-1:0] cnt_load_val;
  logic           cnt_dec;
  logic           cnt_zero;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic ff_d_q, ff_d_d;
  logic ff_en_q, ff_en_d;
  logic ff_clr_n_q, ff_clr_n_d;
  logic ff_pset_n_q, ff_pset_n_d;

  seq_down_cnt #(
    .Width(CntW)
  ) u_cnt (
    .clk_i      (Ck),
    .rst_i      (CLR),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Next-state logic: command acceptance in IDLE, timed phases elsewhere.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (cmd)
            CMD_LOAD: begin
              state_d      = StShift;
              sreg_d       = din;
              cnt_load     = 1'b1;
              cnt_load_val = CntW'(N);
            end
            CMD_CLEAR: begin
              state_d      = StClrp;
              cnt_load     = 1'b1;
              cnt_load_val = CntW'(CLR_CYCLES);
            end
            CMD_PRESET: begin
              state_d      = StPsetp;
              cnt_load     = 1'b1;
              cnt_load_val = CntW'(CLR_CYCLES);
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        sreg_d  = {sreg_q[N-2:0], 1'b0};
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = StDone;
      end
      StClrp, StPsetp: begin
        cnt_dec = 1'b1;
        if (cnt_zero) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Moore output decode from the next state, so outputs land in flops.
  always_comb begin
    busy_d      = (state_d == StShift) || (state_d == StClrp) || (state_d == StPsetp);
    done_d      = (state_d == StDone);
    ff_en_d     = (state_d == StShift);
    ff_d_d      = ff_en_d & sreg_d[N-1];
    ff_clr_n_d  = (state_d != StClrp);
    ff_pset_n_d = (state_d != StPsetp);
  end

  // State and output registers; reset holds the chain in clear.
  always_ff @(posedge Ck) begin
    if (CLR) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ff_d_q      <= 1'b0;
      ff_en_q     <= 1'b0;
      ff_clr_n_q  <= 1'b0;
      ff_pset_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ff_d_q      <= ff_d_d;
      ff_en_q     <= ff_en_d;
      ff_clr_n_q  <= ff_clr_n_d;
      ff_pset_n_q <= ff_pset_n_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ff_d      = ff_d_q;
  assign ff_en     = ff_en_q;
  assign ff_clr_n  = ff_clr_n_q;
  assign ff_pset_n = ff_pset_n_q;

endmodule

// File: tb/tb_shreg_seq.sv
// Directed self-checking bench for shreg_seq with N=8, CLR_CYCLES=2.
module tb_shreg_seq;

  localparam int unsigned N  = 8;
  localparam int unsigned CC = 2;

  logic         Ck;
  logic         CLR;
  logic         start;
  logic [1:0]   cmd;
  logic [N-1:0] din;
  logic         busy, done, ff_d, ff_en, ff_clr_n, ff_pset_n;

  int n_checks = 0;
  int n_fail   = 0;

  shreg_seq #(
    .N          (N),
    .CLR_CYCLES (CC)
  ) dut (
    .Ck        (Ck),
    .CLR       (CLR),
    .start     (start),
    .cmd       (cmd),
    .din       (din),
    .busy      (busy),
    .done      (done),
    .ff_d      (ff_d),
    .ff_en     (ff_en),
    .ff_clr_n  (ff_clr_n),
    .ff_pset_n (ff_pset_n)
  );

  initial Ck = 1'b0;
  always #5 Ck = ~Ck;

  // Reference flop chain driven by the sequencer outputs.
  logic [N-1:0] chain;
  always @(posedge Ck) begin
    if (!ff_clr_n)       chain <= '0;
    else if (!ff_pset_n) chain <= '1;
    else if (ff_en)      chain <= {chain[N-2:0], ff_d};
  end

  // Invariant monitor, sampled mid-cycle.
  logic armed = 1'b0;
  int   inv_both_low = 0;
  int   inv_en_pulse = 0;
  int   inv_d_no_en  = 0;
  int   done_wide    = 0;
  int   done_pulses  = 0;
  logic done_prev    = 1'b0;
  always @(negedge Ck) begin
    if (armed) begin
      if (!ff_clr_n && !ff_pset_n)            inv_both_low++;
      if (ff_en && (!ff_clr_n || !ff_pset_n)) inv_en_pulse++;
      if (ff_d && !ff_en)                     inv_d_no_en++;
      if (done && done_prev)                  done_wide++;
      if (done && !done_prev)                 done_pulses++;
      done_prev = done;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Ck);
    #1;
  endtask

  // Issue a LOAD and follow it to the done pulse, checking the serial stream.
  task automatic do_load(input logic [N-1:0] val);
    logic [N-1:0] pat;
    pat   = val;
    din   = val;
    cmd   = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      check("load_en", ff_en, 1'b1);
      check("load_d", ff_d, pat[N-1-i]);
      check("load_busy", busy, 1'b1);
      check("load_done_early", done, 1'b0);
      step();
    end
    check("load_done", done, 1'b1);
    check("load_done_busy", busy, 1'b0);
    check("load_done_en", ff_en, 1'b0);
    step();
    check("load_done_end", done, 1'b0);
  endtask

  // CLEAR (is_preset=0) or PRESET (is_preset=1) with pulse-width checks.
  task automatic do_pulse(input logic is_preset);
    cmd   = is_preset ? 2'b11 : 2'b10;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < CC; i++) begin
      check("pulse_clr_n", ff_clr_n, is_preset ? 1'b1 : 1'b0);
      check("pulse_pset_n", ff_pset_n, is_preset ? 1'b0 : 1'b1);
      check("pulse_en", ff_en, 1'b0);
      check("pulse_busy", busy, 1'b1);
      step();
    end
    check("pulse_done", done, 1'b1);
    check("pulse_end_clr_n", ff_clr_n, 1'b1);
    check("pulse_end_pset_n", ff_pset_n, 1'b1);
    step();
  endtask

  initial begin
    logic [N-1:0] pat;
    int abort_done;

    CLR   = 1'b1;
    start = 1'b0;
    cmd   = 2'b00;
    din   = '0;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) begin
      step();
      armed = 1'b1;
      check("rst_clr_n", ff_clr_n, 1'b0);
      check("rst_pset_n", ff_pset_n, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_en", ff_en, 1'b0);
    end
    CLR = 1'b0;
    step();
    check("rel_clr_n", ff_clr_n, 1'b1);
    check("rel_busy", busy, 1'b0);
    check("rel_done", done, 1'b0);
    check("rel_chain", chain, 8'h00);

    // LOAD A5.
    do_load(8'hA5);
    check("chain_a5", chain, 8'hA5);

    // LOAD FF, then CLEAR, then PRESET.
    do_load(8'hFF);
    check("chain_ff", chain, 8'hFF);
    do_pulse(1'b0);
    check("chain_clear", chain, 8'h00);
    do_pulse(1'b1);
    check("chain_preset", chain, 8'hFF);

    // start held high through a LOAD; din changed mid-shift.
    pat   = 8'h96;
    din   = pat;
    cmd   = 2'b01;
    start = 1'b1;
    step();
    for (int i = 0; i < N; i++) begin
      check("hold_d", ff_d, pat[N-1-i]);
      check("hold_en", ff_en, 1'b1);
      if (i == 3) din = 8'h00;
      step();
    end
    check("hold_done", done, 1'b1);
    din = 8'h81;
    step();
    check("hold_idle_busy", busy, 1'b0);
    check("hold_idle_done", done, 1'b0);
    step();
    start = 1'b0;
    check("hold_accept_busy", busy, 1'b1);
    check("hold_accept_d", ff_d, 1'b1);
    for (int i = 1; i < N; i++) step();
    check("hold2_en_last", ff_en, 1'b1);
    step();
    check("hold2_done", done, 1'b1);
    step();
    check("chain_81", chain, 8'h81);

    // Abort a LOAD of 3C at shift cycle 4.
    din   = 8'h3C;
    cmd   = 2'b01;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("abort_pre_en", ff_en, 1'b1);
    CLR = 1'b1;
    step();
    check("abort_busy", busy, 1'b0);
    check("abort_en", ff_en, 1'b0);
    check("abort_clr_n", ff_clr_n, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_d", ff_d, 1'b0);
    CLR = 1'b0;
    abort_done = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) abort_done++;
    end
    check("abort_no_done", abort_done, 0);
    check("abort_rel_clr_n", ff_clr_n, 1'b1);

    // NOP is ignored.
    cmd   = 2'b00;
    start = 1'b1;
    step();
    check("nop_busy", busy, 1'b0);
    step();
    start = 1'b0;
    check("nop_busy2", busy, 1'b0);
    check("nop_en", ff_en, 1'b0);
    step();

    // Invariants and done pulse accounting (A5, FF, CLEAR, PRESET, 96, 81).
    check("inv_both_low", inv_both_low, 0);
    check("inv_en_pulse", inv_en_pulse, 0);
    check("inv_d_no_en", inv_d_no_en, 0);
    check("done_width", done_wide, 0);
    check("done_pulses", done_pulses, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
